// File: rtl/bridge_arbiter.sv
// Single-lane bridge arbiter: alternates east/west grants with minimum/maximum
// green time, an all-stop clearance phase and lane occupancy tracking.
module bridge_arbiter #(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 16,
  parameter int unsigned CLEAR_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_e,
  input  logic       req_w,
  input  logic       enter,
  input  logic       leave,
  output logic       grant_e,
  output logic       grant_w,
  output logic       idle,
  output logic [2:0] occ,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_E = 3'd1,
    GRANT_W = 3'd2,
    CLEAR_E = 3'd3,
    CLEAR_W = 3'd4
  } state_t;

  localparam logic [7:0] MIN_M1 = 8'(GREEN_MIN - 1);
  localparam logic [7:0] MAX_M1 = 8'(GREEN_MAX - 1);
  localparam logic [7:0] CLR_M1 = 8'(CLEAR_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       last_w_q, last_w_d;
  logic [2:0] occ_q, occ_d;
  logic       err_q, err_d;
  logic       grant_e_q, grant_w_q, idle_q;

  always_comb begin
    state_d  = state_q;
    last_w_d = last_w_q;
    unique case (state_q)
      IDLE: begin
        // Tie goes to the side that was not served last.
        if (req_e && req_w)  state_d = last_w_q ? GRANT_E : GRANT_W;
        else if (req_e)      state_d = GRANT_E;
        else if (req_w)      state_d = GRANT_W;
      end
      GRANT_E: begin
        if ((timer_q >= MIN_M1 && !req_e) || (timer_q >= MAX_M1 && req_w))
          state_d = CLEAR_E;
      end
      GRANT_W: begin
        if ((timer_q >= MIN_M1 && !req_w) || (timer_q >= MAX_M1 && req_e))
          state_d = CLEAR_W;
      end
      CLEAR_E: begin
        if (timer_q >= CLR_M1 && occ_q == 3'd0) begin
          if (req_w)      state_d = GRANT_W;
          else if (req_e) state_d = GRANT_E;
          else            state_d = IDLE;
        end
      end
      CLEAR_W: begin
        if (timer_q >= CLR_M1 && occ_q == 3'd0) begin
          if (req_e)      state_d = GRANT_E;
          else if (req_w) state_d = GRANT_W;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == GRANT_E && state_q != GRANT_E) last_w_d = 1'b0;
    if (state_d == GRANT_W && state_q != GRANT_W) last_w_d = 1'b1;
  end

  always_comb begin
    if (state_d != state_q)  timer_d = '0;
    else if (timer_q == '1)  timer_d = timer_q;
    else                     timer_d = timer_q + 8'd1;
  end

  // Occupancy saturates at both ends; every anomaly latches err.
  always_comb begin
    occ_d = occ_q;
    err_d = err_q;
    if (enter && !leave) begin
      if (occ_q == 3'd7) err_d = 1'b1;
      else               occ_d = occ_q + 3'd1;
    end else if (leave && !enter) begin
      if (occ_q == 3'd0) err_d = 1'b1;
      else               occ_d = occ_q - 3'd1;
    end
    if (enter && !grant_e_q && !grant_w_q) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      last_w_q  <= 1'b1;
      occ_q     <= '0;
      err_q     <= 1'b0;
      grant_e_q <= 1'b0;
      grant_w_q <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      last_w_q  <= last_w_d;
      occ_q     <= occ_d;
      err_q     <= err_d;
      grant_e_q <= (state_d == GRANT_E);
      grant_w_q <= (state_d == GRANT_W);
      idle_q    <= (state_d == IDLE);
    end
  end

  assign grant_e = grant_e_q;
  assign grant_w = grant_w_q;
  assign idle    = idle_q;
  assign occ     = occ_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Scoreboard bench for bridge_arbiter: directed scenarios plus random traffic
// checked against a phase/side reference model.
module tb_bridge_arbiter;

  localparam int GMIN = 4;
  localparam int GMAX = 16;
  localparam int CLR  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_e = 1'b0, req_w = 1'b0, enter = 1'b0, leave = 1'b0;
  logic       grant_e, grant_w, idle, err;
  logic [2:0] occ;

  int errors = 0;
  int checks = 0;

  logic [6:0] exp_q[$];

  // Reference model: which side owns the bridge (0 none, 1 east, 2 west),
  // whether that side is in its clearance phase, and cycles spent in phase.
  int m_side, m_t, m_last, m_occ;
  bit m_clear, m_err;

  bridge_arbiter #(.GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .CLEAR_CYC(CLR)) dut (
    .clk(clk), .rst_n(rst_n), .req_e(req_e), .req_w(req_w),
    .enter(enter), .leave(leave), .grant_e(grant_e), .grant_w(grant_w),
    .idle(idle), .occ(occ), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_out();
    return {m_side == 1 && !m_clear, m_side == 2 && !m_clear, m_side == 0,
            3'(m_occ), m_err};
  endfunction

  task automatic model_reset();
    m_side = 0; m_clear = 0; m_t = 0; m_last = 2; m_occ = 0; m_err = 0;
  endtask

  task automatic enter_phase(input int side, input bit clr);
    m_side = side; m_clear = clr; m_t = 0;
    if (side != 0 && !clr) m_last = side;
  endtask

  task automatic model_step(input bit re, input bit rw, input bit en, input bit lv);
    int occ_old;
    bit mine, opp, moved;
    occ_old = m_occ;
    if (en && !(m_side != 0 && !m_clear)) m_err = 1;
    if (en && !lv) begin
      if (m_occ == 7) m_err = 1; else m_occ = m_occ + 1;
    end else if (lv && !en) begin
      if (m_occ == 0) m_err = 1; else m_occ = m_occ - 1;
    end
    mine  = (m_side == 1) ? re : rw;
    opp   = (m_side == 1) ? rw : re;
    moved = 1;
    if (m_side == 0) begin
      if (re && rw)  enter_phase(m_last == 1 ? 2 : 1, 0);
      else if (re)   enter_phase(1, 0);
      else if (rw)   enter_phase(2, 0);
      else           moved = 0;
    end else if (!m_clear) begin
      if ((m_t >= GMIN - 1 && !mine) || (m_t >= GMAX - 1 && opp))
        enter_phase(m_side, 1);
      else moved = 0;
    end else begin
      if (m_t >= CLR - 1 && occ_old == 0) begin
        if (opp)       enter_phase(3 - m_side, 0);
        else if (mine) enter_phase(m_side, 0);
        else           enter_phase(0, 0);
      end else moved = 0;
    end
    if (!moved && m_t < 255) m_t = m_t + 1;
  endtask

  task automatic cycle(input bit re, input bit rw, input bit en, input bit lv);
    @(negedge clk);
    rst_n = 1'b1;
    req_e = re; req_w = rw; enter = en; leave = lv;
    model_step(re, rw, en, lv);
    exp_q.push_back(model_out());
  endtask

  task automatic check_reset(input string name);
    checks++;
    if ({grant_e, grant_w, idle, occ, err} !== 7'b0010000) begin
      errors++;
      $display("FAIL %s got ge=%b gw=%b idle=%b occ=%0d err=%b want 0 0 1 0 0",
               name, grant_e, grant_w, idle, occ, err);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_e = 0; req_w = 0; enter = 0; leave = 0;
    model_reset();
    #1 check_reset("sync_reset");
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset("async_reset");
    req_e = 0; req_w = 0; enter = 0; leave = 0;
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [6:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {grant_e, grant_w, idle, occ, err};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got ge=%b gw=%b idle=%b occ=%0d err=%b want ge=%b gw=%b idle=%b occ=%0d err=%b",
                   $time, a[6], a[5], a[4], a[3:1], a[0], e[6], e[5], e[4], e[3:1], e[0]);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin : stim
    bit re, rw;
    model_reset();
    do_reset();

    // East pulse, no traffic.
    repeat (2) cycle(1, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 0);

    // Both sides held from reset release.
    do_reset();
    repeat (45) cycle(1, 1, 0, 0);

    // Three vehicles enter, east drops, clearance waits for the lane to empty.
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (5) cycle(0, 0, 0, 0);

    // Simultaneous enter and leave at occ=2.
    do_reset();
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 1);
    cycle(0, 1, 0, 0);
    repeat (2) cycle(0, 1, 0, 1);
    repeat (8) cycle(0, 0, 0, 0);

    // Underflow, then overflow while ungranted; err sticks until reset.
    do_reset();
    cycle(0, 0, 0, 1);
    repeat (8) begin
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);
    end
    repeat (4) cycle(0, 0, 0, 0);

    // Async reset mid-grant with occ=3, then east preferred on the tie.
    do_reset();
    cycle(0, 1, 0, 0);
    repeat (3) cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    async_reset();
    repeat (6) cycle(1, 1, 0, 0);

    // Random traffic.
    do_reset();
    re = 0; rw = 0;
    for (int i = 0; i < 4000; i++) begin
      bit en, lv, gany;
      if ($urandom_range(7) == 0) re = ~re;
      if ($urandom_range(7) == 0) rw = ~rw;
      gany = (m_side != 0 && !m_clear);
      en = gany ? ($urandom_range(4) == 0) : ($urandom_range(60) == 0);
      lv = ($urandom_range(4) == 0);
      if ($urandom_range(499) == 0) async_reset();
      else if ($urandom_range(599) == 0) do_reset();
      else cycle(re, rw, en, lv);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
